fetch_if_id: RTL and testbench

Fetch-side pipeline control: holds the program counter and the IF/ID pipeline register of the five-stage MIPS core. It sits directly downstream of the hazard detection unit. Each cycle it consumes that unit's `stall`/`flush`/`pc_hazard` decision, plus branch and jump redirects from ID, and either advances, holds, or squashes fetch. It also freezes the front end while instruction memory reports a wait. It provides a stuck-stall watchdog.

---
 rtl/fetch_if_id_if.sv | 49 ++++
 rtl/fetch_if_id.sv | 164 ++++++++++++++++
 tb/tb_fetch_if_id.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_if_id_if.sv
// ============================================================================
// Module      : fetch_if_id_if
// Description : Hazard/redirect/fetch bundle between the ID-side control logic
//               and the fetch front end. Perf ports exist only when
//               FETCH_IF_ID_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_if_id_if;
   logic        stall_i;
   logic [1:0]  flush_i;
   logic        pc_hazard_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        imem_wait_i;
   logic [31:0] inst_i;
   logic [31:0] pc_o;
   logic [31:0] if_id_pc4_o;
   logic [31:0] if_id_inst_o;
   logic        if_id_valid_o;
   logic        stall_err_o;
`ifdef FETCH_IF_ID_PERF_EN
   logic [15:0] perf_hold_cnt_o;
   logic [15:0] perf_flush_cnt_o;
`endif

   modport master (
      output stall_i, flush_i, pc_hazard_i, jump_i, jump_addr_i,
      output branch_i, branch_addr_i, imem_wait_i, inst_i,
`ifdef FETCH_IF_ID_PERF_EN
      input  perf_hold_cnt_o, perf_flush_cnt_o,
`endif
      input  pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o, stall_err_o
   );

   modport slave (
      input  stall_i, flush_i, pc_hazard_i, jump_i, jump_addr_i,
      input  branch_i, branch_addr_i, imem_wait_i, inst_i,
`ifdef FETCH_IF_ID_PERF_EN
      output perf_hold_cnt_o, perf_flush_cnt_o,
`endif
      output pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o, stall_err_o
   );
endinterface

`default_nettype wire

// File: rtl/fetch_if_id.sv
// ============================================================================
// Module      : fetch_if_id
// Description : Program counter and IF/ID register with hazard hold, redirect
//               flush, imem-wait freeze and a sticky stuck-stall watchdog.
//               Optional perf counters: FETCH_IF_ID_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_if_id #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [31:0] NOP_INST    = 32'h0000_0000,
   parameter int unsigned STALL_LIMIT = 15
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   fetch_if_id_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [7:0]  c_STALL_LIMIT = 8'(STALL_LIMIT);
   localparam logic [7:0]  c_HOLD_MAX    = 8'hFF;
   localparam logic [31:0] c_PC_STEP     = 32'd4;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_pc4;
   logic [31:0] w_pc4_nxt;
   logic [31:0] r_inst;
   logic [31:0] w_inst_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic [7:0]  r_hold_cnt;
   logic [7:0]  w_hold_cnt_nxt;
   logic        r_stall_err;
   logic        w_stall_err_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_redirect;

   assign w_pc_plus4 = r_pc + c_PC_STEP;

   // Jump outranks branch; with neither, a flush simply steps past the slot.
   always_comb begin
      w_redirect = w_pc_plus4;
      if (bus.jump_i) begin
         w_redirect = bus.jump_addr_i;
      end else if (bus.branch_i) begin
         w_redirect = bus.branch_addr_i;
      end
   end

   // Next-state decision; stall_i is advisory only.
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.imem_wait_i) begin
         if (bus.flush_i[0]) begin
            w_state_nxt = FLUSH;
         end else if ((bus.flush_i == 2'b00) || bus.pc_hazard_i) begin
            w_state_nxt = HOLD;
         end else begin
            w_state_nxt = RUN;
         end
      end
   end

   always_comb begin
      w_pc_nxt        = r_pc;
      w_pc4_nxt       = r_pc4;
      w_inst_nxt      = r_inst;
      w_valid_nxt     = r_valid;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_stall_err_nxt = r_stall_err;
      if (!bus.imem_wait_i) begin
         case (w_state_nxt)
            FLUSH: begin
               w_pc_nxt       = w_redirect;
               w_pc4_nxt      = 32'h0000_0000;
               w_inst_nxt     = NOP_INST;
               w_valid_nxt    = 1'b0;
               w_hold_cnt_nxt = 8'h00;
            end
            HOLD: begin
               if (r_hold_cnt != c_HOLD_MAX) begin
                  w_hold_cnt_nxt = r_hold_cnt + 8'h01;
               end
               if (w_hold_cnt_nxt == c_STALL_LIMIT) begin
                  w_stall_err_nxt = 1'b1;
               end
            end
            RUN: begin
               w_pc_nxt       = w_pc_plus4;
               w_pc4_nxt      = w_pc_plus4;
               w_inst_nxt     = bus.inst_i;
               w_valid_nxt    = 1'b1;
               w_hold_cnt_nxt = 8'h00;
            end
            default: begin
               w_hold_cnt_nxt = r_hold_cnt;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_pc        <= PC_RESET;
         r_pc4       <= 32'h0000_0000;
         r_inst      <= NOP_INST;
         r_valid     <= 1'b0;
         r_hold_cnt  <= 8'h00;
         r_stall_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_pc4       <= w_pc4_nxt;
         r_inst      <= w_inst_nxt;
         r_valid     <= w_valid_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_stall_err <= w_stall_err_nxt;
      end
   end

   assign bus.pc_o          = r_pc;
   assign bus.if_id_pc4_o   = r_pc4;
   assign bus.if_id_inst_o  = r_inst;
   assign bus.if_id_valid_o = r_valid;
   assign bus.stall_err_o   = r_stall_err;

`ifdef FETCH_IF_ID_PERF_EN
   localparam logic [15:0] c_PERF_MAX = 16'hFFFF;

   logic [15:0] r_perf_hold;
   logic [15:0] r_perf_flush;

   // Wait cycles are frozen cycles, so they are attributed to neither counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_hold  <= 16'h0000;
         r_perf_flush <= 16'h0000;
      end else if (!bus.imem_wait_i) begin
         if ((w_state_nxt == HOLD) && (r_perf_hold != c_PERF_MAX)) begin
            r_perf_hold <= r_perf_hold + 16'h0001;
         end
         if ((w_state_nxt == FLUSH) && (r_perf_flush != c_PERF_MAX)) begin
            r_perf_flush <= r_perf_flush + 16'h0001;
         end
      end
   end

   assign bus.perf_hold_cnt_o  = r_perf_hold;
   assign bus.perf_flush_cnt_o = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id.sv
// ============================================================================
// Module      : tb_fetch_if_id
// Description : Directed self-checking bench for fetch_if_id.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_if_id;

   logic clk;
   logic rst;
   int   checks = 0;
   int   passes = 0;

   fetch_if_id_if bus ();

   fetch_if_id #(
      .PC_RESET    (32'h0000_0000),
      .NOP_INST    (32'h0000_0000),
      .STALL_LIMIT (15)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic [31:0] inst,
                           input logic valid);
      chk({tag, " pc"},    bus.pc_o,          pc);
      chk({tag, " pc4"},   bus.if_id_pc4_o,   pc4);
      chk({tag, " inst"},  bus.if_id_inst_o,  inst);
      chk({tag, " valid"}, {31'd0, bus.if_id_valid_o}, {31'd0, valid});
   endtask

   initial begin
      rst               = 1'b1;
      bus.stall_i       = 1'b0;
      bus.flush_i       = 2'b10;
      bus.pc_hazard_i   = 1'b0;
      bus.jump_i        = 1'b0;
      bus.jump_addr_i   = 32'h0;
      bus.branch_i      = 1'b0;
      bus.branch_addr_i = 32'h0;
      bus.imem_wait_i   = 1'b0;
      bus.inst_i        = 32'h0;
      step();
      step();
      chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("reset err", {31'd0, bus.stall_err_o}, 32'd0);

      // Sequential fetch
      rst = 1'b0;
      bus.inst_i = 32'hA000_0001; step();
      chk_ifid("seq0", 32'h4, 32'h4, 32'hA000_0001, 1'b1);
      bus.inst_i = 32'hA000_0002; step();
      chk_ifid("seq1", 32'h8, 32'h8, 32'hA000_0002, 1'b1);
      bus.inst_i = 32'hA000_0003; step();
      chk_ifid("seq2", 32'hC, 32'hC, 32'hA000_0003, 1'b1);

      // Load-use hold for one cycle, stall_i low (informational only)
      bus.flush_i = 2'b00; bus.pc_hazard_i = 1'b1; bus.inst_i = 32'hA000_0004;
      step();
      chk_ifid("hold", 32'hC, 32'hC, 32'hA000_0003, 1'b1);
      bus.flush_i = 2'b10; bus.pc_hazard_i = 1'b0; step();
      chk_ifid("resume", 32'h10, 32'h10, 32'hA000_0004, 1'b1);

      // pc_hazard alone forces hold even with advance code
      bus.pc_hazard_i = 1'b1; bus.stall_i = 1'b1; bus.inst_i = 32'hA000_0005;
      step();
      chk_ifid("hazhold", 32'h10, 32'h10, 32'hA000_0004, 1'b1);

      // Flush beats pc_hazard; taken branch
      bus.flush_i = 2'b01; bus.branch_i = 1'b1; bus.branch_addr_i = 32'h40;
      step();
      chk_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0);
      bus.pc_hazard_i = 1'b0; bus.stall_i = 1'b0;

      // Jump and branch together (code 11 acts as flush)
      bus.flush_i = 2'b11; bus.jump_i = 1'b1; bus.jump_addr_i = 32'h100;
      step();
      chk_ifid("jump", 32'h100, 32'h0, 32'h0, 1'b0);

      // Flush with no redirect steps PC by 4
      bus.flush_i = 2'b01; bus.jump_i = 1'b0; bus.branch_i = 1'b0; step();
      chk("flush plain pc", bus.pc_o, 32'h104);

      bus.flush_i = 2'b10; bus.inst_i = 32'hA000_0006; step();
      chk_ifid("run2", 32'h108, 32'h108, 32'hA000_0006, 1'b1);

      // Memory wait during a redirect: frozen, then redirect applies
      bus.imem_wait_i = 1'b1; bus.flush_i = 2'b01; bus.branch_i = 1'b1;
      bus.branch_addr_i = 32'h200; bus.inst_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("wait", 32'h108, 32'h108, 32'hA000_0006, 1'b1);
      end
      bus.imem_wait_i = 1'b0; step();
      chk_ifid("after wait", 32'h200, 32'h0, 32'h0, 1'b0);

      // PC wrap
      bus.branch_i = 1'b0; bus.jump_i = 1'b1; bus.jump_addr_i = 32'hFFFF_FFFC;
      step();
      chk("wrap tgt", bus.pc_o, 32'hFFFF_FFFC);
      bus.jump_i = 1'b0; bus.flush_i = 2'b10; bus.inst_i = 32'hA000_0007; step();
      chk_ifid("wrap", 32'h0, 32'h0, 32'hA000_0007, 1'b1);

      // Watchdog: 7 holds, 3 wait cycles (not counted), 7 more holds
      bus.flush_i = 2'b00;
      for (int i = 0; i < 7; i++) step();
      bus.imem_wait_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.imem_wait_i = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("wdog 14", {31'd0, bus.stall_err_o}, 32'd0);
      step();
      chk("wdog 15", {31'd0, bus.stall_err_o}, 32'd1);
      chk("wdog pc", bus.pc_o, 32'h0);
      bus.flush_i = 2'b10; step();
      chk("wdog sticky", {31'd0, bus.stall_err_o}, 32'd1);
      chk("wdog run pc", bus.pc_o, 32'h4);

`ifdef FETCH_IF_ID_PERF_EN
      // 1 + 1 + 15 holds; branch, jump, plain, post-wait, wrap flushes
      chk("perf hold",  {16'd0, bus.perf_hold_cnt_o},  32'd17);
      chk("perf flush", {16'd0, bus.perf_flush_cnt_o}, 32'd5);
`endif

      rst = 1'b1; step();
      chk("rst err", {31'd0, bus.stall_err_o}, 32'd0);
      chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
